// File: rtl/load_unit_pkg.sv
// Shared load-unit definitions: load operation codes, FSM state encoding and the state type.
// Load codes follow the RISC-V funct3 layout so the decoder can pass funct3 through unchanged.
package load_unit_pkg;

  localparam int LOAD_OP_WIDTH = 3;

  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'b000;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'b001;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'b010;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'b100;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'b101;

  localparam logic [1:0] LU_IDLE  = 2'd0;
  localparam logic [1:0] LU_REQ   = 2'd1;
  localparam logic [1:0] LU_RESP  = 2'd2;
  localparam logic [1:0] LU_FAULT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = LU_IDLE,
    ST_REQ   = LU_REQ,
    ST_RESP  = LU_RESP,
    ST_FAULT = LU_FAULT
  } lu_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword/word selection and sign/zero extension of a fetched bus word.
// Kept standalone so the AMO path can share it; unknown op codes behave as LB.
module load_extend
  import load_unit_pkg::*;
(
  input  logic [LOAD_OP_WIDTH-1:0] op,
  input  logic [1:0]               off,
  input  logic [31:0]              word,
  output logic [31:0]              result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    case (off)
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      2'd3:    w_byte = word[31:24];
      default: w_byte = word[7:0];
    endcase
    w_half = off[1] ? word[31:16] : word[15:0];

    result = {{24{w_byte[7]}}, w_byte};
    case (op)
      LOAD_OP_LW:  result = word;
      LOAD_OP_LH:  result = {{16{w_half[15]}}, w_half};
      LOAD_OP_LHU: result = {16'h0000, w_half};
      LOAD_OP_LBU: result = {24'h000000, w_byte};
      default:     result = {{24{w_byte[7]}}, w_byte};
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load execution stage: word read over a valid/ready bus, then byte/half/word extraction.
// Reports completion, misalignment or bus timeout as one-cycle pulses to the core control.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [LOAD_OP_WIDTH-1:0] LOADop,
  input  logic                     is_load_unaligned,
  input  logic [31:0]              addr,
  output logic                     mem_valid,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic [31:0]              rd_data,
  output logic                     done,
  output logic                     misaligned,
  output logic                     access_fault,
  output logic                     busy
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  lu_state_e                r_state;
  lu_state_e                w_next_state;
  logic [LOAD_OP_WIDTH-1:0] r_op;
  logic [1:0]               r_off;
  logic [31:0]              r_mem_addr;
  logic [31:0]              r_rd_data;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic                     r_access_fault;
  logic [31:0]              w_ext;
  logic                     w_accept;
  logic                     w_handshake;
  logic                     w_timeout;

  load_extend u_extend (
    .op     (r_op),
    .off    (r_off),
    .word   (mem_rdata),
    .result (w_ext)
  );

  assign w_accept    = (r_state == ST_IDLE) && start && !is_load_unaligned;
  assign w_handshake = (r_state == ST_REQ) && mem_ready;
  // A handshake in the limit cycle takes priority over the timeout.
  assign w_timeout   = TO_EN && (r_state == ST_REQ) && !mem_ready && (r_cnt == LIMIT);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = is_load_unaligned ? ST_FAULT : ST_REQ;
      end
      ST_REQ: begin
        if (w_handshake)    w_next_state = ST_RESP;
        else if (w_timeout) w_next_state = ST_IDLE;
      end
      ST_RESP:  w_next_state = ST_IDLE;
      ST_FAULT: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_op           <= '0;
      r_off          <= '0;
      r_mem_addr     <= '0;
      r_rd_data      <= '0;
      r_cnt          <= '0;
      r_access_fault <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_access_fault <= w_timeout;
      if (w_accept) begin
        r_op       <= LOADop;
        r_off      <= addr[1:0];
        r_mem_addr <= {addr[31:2], 2'b00};
        r_cnt      <= '0;
      end else if (w_handshake) begin
        r_rd_data <= w_ext;
      end else if ((r_state == ST_REQ) && !w_timeout) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign mem_valid    = (r_state == ST_REQ);
  assign mem_addr     = r_mem_addr;
  assign rd_data      = r_rd_data;
  assign done         = (r_state == ST_RESP);
  assign misaligned   = (r_state == ST_FAULT);
  assign access_fault = r_access_fault;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed vectors, randomized loads against a reference
// model, misalignment, timeout (second instance with TIMEOUT_CYCLES=4) and reset during a request.
module tb_load_unit;
  import load_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  loadOp = '0;
  logic        unaligned = 1'b0;
  logic [31:0] addr = '0;
  logic        memReady = 1'b0;
  logic [31:0] memRdata = '0;
  logic        memValid, done, misaligned, accessFault, busy;
  logic [31:0] memAddr, rdData;

  logic        toStart = 1'b0;
  logic        toReady = 1'b0;
  logic        toValid, toDone, toMisaligned, toFault, toBusy;
  logic [31:0] toAddr, toRdData;

  int total = 0;
  int bad = 0;
  logic [31:0] lastRd = '0;

  always #5 clk = ~clk;

  load_unit #(.TIMEOUT_CYCLES(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .LOADop(loadOp),
    .is_load_unaligned(unaligned), .addr(addr), .mem_valid(memValid),
    .mem_addr(memAddr), .mem_ready(memReady), .mem_rdata(memRdata),
    .rd_data(rdData), .done(done), .misaligned(misaligned),
    .access_fault(accessFault), .busy(busy)
  );

  load_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(16)) toDut (
    .clk(clk), .resetn(resetn), .start(toStart), .LOADop(loadOp),
    .is_load_unaligned(unaligned), .addr(addr), .mem_valid(toValid),
    .mem_addr(toAddr), .mem_ready(toReady), .mem_rdata(memRdata),
    .rd_data(toRdData), .done(toDone), .misaligned(toMisaligned),
    .access_fault(toFault), .busy(toBusy)
  );

  // Reference: shift the addressed lane down, mask, then extend by load type.
  function automatic logic [31:0] refLoad(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
    h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
    case (op)
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      default: return b[7] ? (b | 32'hFFFF_FF00) : b;
    endcase
  endfunction

  // Runs one load on the main instance starting just after a falling edge.
  task automatic runLoad(input logic [2:0] op, input logic [31:0] a, input logic [31:0] word,
                         input int waits, input logic [31:0] expRd, input bit pokeStart,
                         input bit holdStartAtDone, input string name);
    start = 1'b1; loadOp = op; addr = a; unaligned = 1'b0; memReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      total++;
      if (memValid !== 1'b1) begin
        bad++; $display("[TB] FAIL %s mem_valid wait %0d: got %b want 1", name, i, memValid);
      end
      total++;
      if (memAddr !== {a[31:2], 2'b00}) begin
        bad++; $display("[TB] FAIL %s mem_addr wait %0d: got %h want %h", name, i, memAddr,
                        {a[31:2], 2'b00});
      end
      total++;
      if (done !== 1'b0) begin
        bad++; $display("[TB] FAIL %s early done wait %0d: got %b want 0", name, i, done);
      end
      memReady = (i == waits);
      memRdata = (i == waits) ? word : $urandom;
      if (pokeStart && i == 0) begin
        start = 1'b1; addr = a ^ 32'h0000_0104; loadOp = ~op; unaligned = $urandom_range(0, 1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    memReady = 1'b0; start = holdStartAtDone; addr = $urandom; unaligned = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++; $display("[TB] FAIL %s done: got %b want 1", name, done);
    end
    total++;
    if (rdData !== expRd) begin
      bad++; $display("[TB] FAIL %s rd_data: got %h want %h", name, rdData, expRd);
    end
    total++;
    if (memValid !== 1'b0) begin
      bad++; $display("[TB] FAIL %s mem_valid after handshake: got %b want 0", name, memValid);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL %s return to idle: got done=%b busy=%b want 0 0", name, done, busy);
    end
    total++;
    if (rdData !== expRd) begin
      bad++; $display("[TB] FAIL %s rd_data hold: got %h want %h", name, rdData, expRd);
    end
    lastRd = expRd;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({memValid, done, misaligned, accessFault, busy} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset flags: got %b want 00000",
                      {memValid, done, misaligned, accessFault, busy});
    end
    total++;
    if (memAddr !== 32'h0 || rdData !== 32'h0) begin
      bad++; $display("[TB] FAIL reset data: got addr=%h rd=%h want 0 0", memAddr, rdData);
    end
    resetn = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL idle ready ignored: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    runLoad(LOAD_OP_LW,  32'h0000_1000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 0, "lw");
    runLoad(LOAD_OP_LB,  32'h0000_2003, 32'h80FF_1234, 0, 32'hFFFF_FF80, 0, 0, "lb");
    runLoad(LOAD_OP_LBU, 32'h0000_2003, 32'h80FF_1234, 2, 32'h0000_0080, 0, 0, "lbu");
    runLoad(LOAD_OP_LH,  32'h0000_2002, 32'h80FF_1234, 0, 32'hFFFF_80FF, 0, 0, "lh");
    runLoad(LOAD_OP_LHU, 32'h0000_2002, 32'h80FF_1234, 3, 32'h0000_80FF, 0, 0, "lhu");
    runLoad(3'd7,        32'h0000_2001, 32'h0000_9200, 0, 32'hFFFF_FF92, 0, 0, "unknown op");
  endtask

  task automatic test_misaligned();
    start = 1'b1; loadOp = LOAD_OP_LW; addr = 32'h0000_3001; unaligned = 1'b1;
    @(negedge clk);
    start = 1'b0; unaligned = 1'b0;
    total++;
    if (misaligned !== 1'b1 || memValid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL misaligned pulse: got mis=%b valid=%b done=%b busy=%b want 1 0 0 1",
                      misaligned, memValid, done, busy);
    end
    @(negedge clk);
    total++;
    if (misaligned !== 1'b0 || memValid !== 1'b0 || busy !== 1'b0 || rdData !== lastRd) begin
      bad++; $display("[TB] FAIL misaligned end: got mis=%b valid=%b busy=%b rd=%h want 0 0 0 %h",
                      misaligned, memValid, busy, rdData, lastRd);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] w;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0: op = LOAD_OP_LB;
        1: op = LOAD_OP_LBU;
        2: op = LOAD_OP_LH;
        3: op = LOAD_OP_LHU;
        4: op = LOAD_OP_LW;
        default: op = 3'($urandom_range(6, 7));
      endcase
      a = $urandom;
      if (op == LOAD_OP_LH || op == LOAD_OP_LHU) a[0] = 1'b0;
      if (op == LOAD_OP_LW) a[1:0] = 2'b00;
      w = $urandom;
      runLoad(op, a, w, $urandom_range(0, 7), refLoad(op, a, w), n[0], 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    runLoad(LOAD_OP_LBU, 32'h0000_7001, 32'h1122_3344, 0, 32'h0000_0033, 0, 1, "b2b first");
    runLoad(LOAD_OP_LH,  32'h0000_7002, 32'hF00D_0000, 0, 32'hFFFF_F00D, 0, 0, "b2b second");
  endtask

  task automatic test_timeout();
    toStart = 1'b1; loadOp = LOAD_OP_LW; addr = 32'h0000_5004; unaligned = 1'b0; toReady = 1'b0;
    @(negedge clk);
    toStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (toValid !== 1'b1 || toFault !== 1'b0 || toAddr !== 32'h0000_5004) begin
        bad++; $display("[TB] FAIL timeout wait %0d: got valid=%b fault=%b addr=%h want 1 0 00005004",
                        i, toValid, toFault, toAddr);
      end
      @(negedge clk);
    end
    total++;
    if (toFault !== 1'b1 || toValid !== 1'b0 || toBusy !== 1'b0 || toDone !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout pulse: got fault=%b valid=%b busy=%b done=%b want 1 0 0 0",
                      toFault, toValid, toBusy, toDone);
    end
    @(negedge clk);
    total++;
    if (toFault !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout pulse width: got %b want 0", toFault);
    end

    toStart = 1'b1; addr = 32'h0000_5008;
    @(negedge clk);
    toStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (toValid !== 1'b1 || toFault !== 1'b0) begin
        bad++; $display("[TB] FAIL limit wait %0d: got valid=%b fault=%b want 1 0", i, toValid, toFault);
      end
      toReady = (i == 3);
      memRdata = 32'h1234_5678;
      @(negedge clk);
    end
    toReady = 1'b0;
    total++;
    if (toDone !== 1'b1 || toFault !== 1'b0 || toRdData !== 32'h1234_5678) begin
      bad++; $display("[TB] FAIL ready at limit: got done=%b fault=%b rd=%h want 1 0 12345678",
                      toDone, toFault, toRdData);
    end
    @(negedge clk);
    total++;
    if (toFault !== 1'b0 || toBusy !== 1'b0) begin
      bad++; $display("[TB] FAIL after limit: got fault=%b busy=%b want 0 0", toFault, toBusy);
    end
  endtask

  task automatic test_reset_mid_req();
    start = 1'b1; loadOp = LOAD_OP_LW; addr = 32'h0000_6000; unaligned = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (memValid !== 1'b1) begin
      bad++; $display("[TB] FAIL mid-req setup: got valid=%b want 1", memValid);
    end
    resetn = 1'b0; memReady = 1'b1; memRdata = 32'hAAAA_5555;
    @(negedge clk);
    total++;
    if ({memValid, done, misaligned, accessFault, busy} !== 5'b0 || memAddr !== 32'h0 ||
        rdData !== 32'h0) begin
      bad++; $display("[TB] FAIL reset mid-req: got flags=%b addr=%h rd=%h want 00000 0 0",
                      {memValid, done, misaligned, accessFault, busy}, memAddr, rdData);
    end
    resetn = 1'b1; memReady = 1'b0;
    lastRd = 32'h0;
    @(negedge clk);
    runLoad(LOAD_OP_LHU, 32'h0000_4002, 32'hBEEF_0000, 2, 32'h0000_BEEF, 0, 0, "lhu after reset");
  endtask

  initial begin
    $display("[TB] load_unit bench start");
    test_reset();
    test_directed();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
